// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit multicycle CPU: opcodes, control states,
// ALU operation codes and instruction field positions.
package cpu_pkg;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // The four ALU opcodes share a clear MSB and carry the ALU code in [1:0].
    function automatic logic is_alu_op(input logic [2:0] opc);
        return (opc[2] == 1'b0);
    endfunction

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Data-memory wait counter: cleared on MEM entry, counts wait cycles and
// flags a timeout once it reaches MEM_TIMEOUT (0 disables the timeout).
module mc_mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [7:0] LIMIT  = 8'(MEM_TIMEOUT);
    localparam bit         TMO_EN = (MEM_TIMEOUT != 0);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Saturate so a disabled timeout never wraps back into a false match.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout = TMO_EN && (count_q == LIMIT);

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle control FSM for the 8-bit CPU. Define CTRL_HALT_EN to make
// opcode 111 enter a sticky HALT state; otherwise it executes as a NOP.
module mc_ctrl_unit
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] instr,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       pc_src,
    output logic       ir_we,
    output logic       rf_we,
    output logic       wb_sel,
    output logic [1:0] alu_op,
    output logic       mem_req,
    output logic       mem_we,
    output logic [2:0] state,
    output logic       mem_err
);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] opcode_q;
    logic [2:0] opcode_d;
    logic       mem_err_q;
    logic       mem_err_d;

    logic       tmr_clear;
    logic       tmr_enable;
    logic       timeout;

    logic       pc_we_c;
    logic       pc_src_c;
    logic       ir_we_c;
    logic       rf_we_c;
    logic       wb_sel_c;
    logic [1:0] alu_op_c;
    logic       mem_req_c;
    logic       mem_we_c;

    logic       unused_instr_bits;
    assign unused_instr_bits = ^instr[OPC_LSB-1:0];

    mc_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .timeout (timeout)
    );

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        mem_err_d  = mem_err_q;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;
        pc_we_c    = 1'b0;
        pc_src_c   = 1'b0;
        ir_we_c    = 1'b0;
        rf_we_c    = 1'b0;
        wb_sel_c   = 1'b0;
        alu_op_c   = ALU_ADD;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                ir_we_c  = 1'b1;
                pc_we_c  = 1'b1;
                opcode_d = instr[OPC_MSB:OPC_LSB];
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (is_alu_op(opcode_q)) begin
                    rf_we_c  = 1'b1;
                    alu_op_c = opcode_q[1:0];
                end else begin
                    case (opcode_q)
                        OP_LOAD, OP_STORE: begin
                            tmr_clear = 1'b1;
                            state_d   = ST_MEM;
                        end
                        OP_JMP: begin
                            pc_we_c  = 1'b1;
                            pc_src_c = 1'b1;
                        end
                        default: begin
`ifdef CTRL_HALT_EN
                            state_d = ST_HALT;
`else
                            state_d = ST_FETCH;
`endif
                        end
                    endcase
                end
            end
            // A ready response in the timeout cycle still completes the access.
            ST_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = (opcode_q == OP_STORE);
                if (mem_ready) begin
                    state_d = (opcode_q == OP_LOAD) ? ST_WB : ST_FETCH;
                end else if (timeout) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            ST_WB: begin
                rf_we_c  = 1'b1;
                wb_sel_c = 1'b1;
                state_d  = ST_FETCH;
            end
`ifdef CTRL_HALT_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            opcode_q  <= OP_ADD;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Reset forces every control output low immediately, not at the next edge.
    assign pc_we   = pc_we_c   & rst_n;
    assign pc_src  = pc_src_c  & rst_n;
    assign ir_we   = ir_we_c   & rst_n;
    assign rf_we   = rf_we_c   & rst_n;
    assign wb_sel  = wb_sel_c  & rst_n;
    assign alu_op  = alu_op_c  & {2{rst_n}};
    assign mem_req = mem_req_c & rst_n;
    assign mem_we  = mem_we_c  & rst_n;
    assign state   = state_q;
    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Scoreboard bench for mc_ctrl_unit: an instruction-level model expands each
// issued instruction into expected per-cycle outputs checked by a monitor.
module tb_mc_ctrl_unit;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] instr;
    logic       mem_ready;
    logic       pc_we;
    logic       pc_src;
    logic       ir_we;
    logic       rf_we;
    logic       wb_sel;
    logic [1:0] alu_op;
    logic       mem_req;
    logic       mem_we;
    logic [2:0] state;
    logic       mem_err;

    mc_ctrl_unit #(
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .mem_ready (mem_ready),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .ir_we     (ir_we),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .alu_op    (alu_op),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .state     (state),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    logic [12:0] exp_q[$];
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          n_cycles  = 0;
    bit          mon_en    = 1'b0;
    bit          model_err = 1'b0;

    // Record layout: {state, pc_we, pc_src, ir_we, rf_we, wb_sel, alu_op, mem_req, mem_we, mem_err}
    function automatic logic [12:0] rec(input logic [2:0] st, input logic pcwe, input logic pcsrc,
                                        input logic irwe, input logic rfwe, input logic wbsel,
                                        input logic [1:0] aop, input logic mreq, input logic mwe,
                                        input logic merr);
        return {st, pcwe, pcsrc, irwe, rfwe, wbsel, aop, mreq, mwe, merr};
    endfunction

    // Monitor: one expected record per clock cycle, sampled mid-cycle.
    always @(negedge clk) begin
        logic [12:0] got;
        logic [12:0] want;
        if (mon_en) begin
            got = {state, pc_we, pc_src, ir_we, rf_we, wb_sel, alu_op, mem_req, mem_we, mem_err};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("[TB] FAIL scoreboard_underflow cycle %0d: got %b, required an expected entry",
                         n_cycles, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_errors++;
                    $display("[TB] FAIL cycle_outputs cycle %0d: got %b required %b (st,pcwe,pcsrc,irwe,rfwe,wbsel,aop,mreq,mwe,err)",
                             n_cycles, got, want);
                end
            end
            n_cycles++;
        end
    end

    task automatic check_output(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic step(input logic [12:0] r);
        exp_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        model_err = 1'b0;
        repeat (n) begin
            instr     = 8'($urandom);
            mem_ready = 1'($urandom);
            step(rec(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        end
        rst_n = 1'b1;
    endtask

    // rdy_at: index of the MEM cycle in which mem_ready is driven high.
    task automatic apply_instr(input logic [7:0] ins, input int rdy_at);
        logic [2:0] op;
        int         i;
        bit         done;
        op = ins[7:5];

        instr     = ins;
        mem_ready = 1'($urandom);
        step(rec(3'd0, 1, 0, 1, 0, 0, 2'b00, 0, 0, model_err));

        instr     = 8'($urandom);
        mem_ready = 1'($urandom);
        step(rec(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 0, model_err));

        instr     = 8'($urandom);
        mem_ready = 1'($urandom);
        if (op[2] == 1'b0)
            step(rec(3'd2, 0, 0, 0, 1, 0, op[1:0], 0, 0, model_err));
        else if (op == 3'b110)
            step(rec(3'd2, 1, 1, 0, 0, 0, 2'b00, 0, 0, model_err));
        else
            step(rec(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, model_err));

        if (op == 3'b100 || op == 3'b101) begin
            i    = 0;
            done = 1'b0;
            while (!done) begin
                instr     = 8'($urandom);
                mem_ready = (i == rdy_at);
                step(rec(3'd3, 0, 0, 0, 0, 0, 2'b00, 1, (op == 3'b101), model_err));
                if (i == rdy_at) begin
                    done = 1'b1;
                    if (op == 3'b100) begin
                        instr     = 8'($urandom);
                        mem_ready = 1'($urandom);
                        step(rec(3'd4, 0, 0, 0, 1, 1, 2'b00, 0, 0, model_err));
                    end
                end else if (i == TMO) begin
                    model_err = 1'b1;
                    done      = 1'b1;
                end
                i++;
            end
        end

`ifdef CTRL_HALT_EN
        if (op == 3'b111) begin
            repeat (20) begin
                instr     = 8'($urandom);
                mem_ready = 1'($urandom);
                step(rec(3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 0, model_err));
            end
            do_reset(2);
        end
`endif
    endtask

    // LOAD that never completes, with reset pulled in the middle of MEM.
    task automatic abort_test();
        instr     = {3'b100, 5'($urandom)};
        mem_ready = 1'b0;
        step(rec(3'd0, 1, 0, 1, 0, 0, 2'b00, 0, 0, model_err));
        instr = 8'($urandom);
        step(rec(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 0, model_err));
        step(rec(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, model_err));
        step(rec(3'd3, 0, 0, 0, 0, 0, 2'b00, 1, 0, model_err));
        step(rec(3'd3, 0, 0, 0, 0, 0, 2'b00, 1, 0, model_err));
        exp_q.push_back(rec(3'd3, 0, 0, 0, 0, 0, 2'b00, 1, 0, model_err));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("abort_mem_req", int'(mem_req), 0);
        check_output("abort_rf_we", int'(rf_we), 0);
        check_output("abort_mem_err", int'(mem_err), 0);
        check_output("abort_state", int'(state), 0);
        model_err = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);
    endtask

    initial begin
        logic [2:0] op;
        int         r;
        int         rdy;
        int         max_op;

        rst_n     = 1'b0;
        instr     = 8'h00;
        mem_ready = 1'b0;
        mon_en    = 1'b1;
        @(posedge clk);
        #1;
        do_reset(3);

        apply_instr(8'b000_001_01, 0);
        apply_instr(8'b101_001_00, 3);
        apply_instr(8'b100_010_00, 0);
        apply_instr(8'b110_000_00, 0);
        apply_instr(8'b001_011_10, 0);
        apply_instr(8'b010_100_01, 0);
        apply_instr(8'b011_111_11, 0);
        apply_instr(8'b100_001_00, TMO);
        apply_instr(8'b101_010_00, TMO + 1);
        apply_instr(8'b100_000_00, 1000);
        apply_instr(8'b000_010_01, 0);
        abort_test();

`ifdef CTRL_HALT_EN
        max_op = 6;
`else
        max_op = 7;
`endif
        apply_instr(8'b000_000_00, 0);
        repeat (60) begin
            op  = 3'($urandom_range(0, max_op));
            r   = $urandom_range(0, 9);
            rdy = (r < 7) ? $urandom_range(0, 3) : $urandom_range(TMO - 2, TMO + 3);
            apply_instr({op, 5'($urandom)}, rdy);
        end

        apply_instr(8'b111_000_00, 0);
        apply_instr(8'b000_001_01, 0);

        mon_en = 1'b0;
        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
